// File: rtl/wb_commit_trace_if.sv
// Write-back stage bundle: dual-issue W-stage inputs, regfile and HI/LO write
// ports, and the single-port debug trace with its backpressure and stall.
interface wb_commit_trace_if #(
    parameter int CNT_W = 32
);
    logic             wb_fire;
    logic             W_master_reg_wen;
    logic             W_master_memtoReg;
    logic             W_master_hilowrite;
    logic [4:0]       W_master_reg_waddr;
    logic [7:0]       W_master_except;
    logic [31:0]      W_master_pc;
    logic [31:0]      W_master_alu_res;
    logic [31:0]      W_master_mem_rdata;
    logic [63:0]      W_master_alu_out64;
    logic             W_slave_reg_wen;
    logic [4:0]       W_slave_reg_waddr;
    logic [7:0]       W_slave_except;
    logic [31:0]      W_slave_pc;
    logic [31:0]      W_slave_alu_res;

    logic             rf_we1;
    logic [4:0]       rf_waddr1;
    logic [31:0]      rf_wdata1;
    logic             rf_we2;
    logic [4:0]       rf_waddr2;
    logic [31:0]      rf_wdata2;
    logic             hilo_we;
    logic [63:0]      hilo_wdata;

    logic             trace_ready;
    logic [31:0]      debug_wb_pc;
    logic [3:0]       debug_wb_rf_wen;
    logic [4:0]       debug_wb_rf_wnum;
    logic [31:0]      debug_wb_rf_wdata;
    logic             stall_req;
    logic [CNT_W-1:0] commit_cnt;

    // Pipeline / trace-sink side.
    modport master (
        output wb_fire, W_master_reg_wen, W_master_memtoReg, W_master_hilowrite,
               W_master_reg_waddr, W_master_except, W_master_pc, W_master_alu_res,
               W_master_mem_rdata, W_master_alu_out64, W_slave_reg_wen,
               W_slave_reg_waddr, W_slave_except, W_slave_pc, W_slave_alu_res,
               trace_ready,
        input  rf_we1, rf_waddr1, rf_wdata1, rf_we2, rf_waddr2, rf_wdata2,
               hilo_we, hilo_wdata, debug_wb_pc, debug_wb_rf_wen,
               debug_wb_rf_wnum, debug_wb_rf_wdata, stall_req, commit_cnt
    );

    // Write-back / trace block side.
    modport slave (
        input  wb_fire, W_master_reg_wen, W_master_memtoReg, W_master_hilowrite,
               W_master_reg_waddr, W_master_except, W_master_pc, W_master_alu_res,
               W_master_mem_rdata, W_master_alu_out64, W_slave_reg_wen,
               W_slave_reg_waddr, W_slave_except, W_slave_pc, W_slave_alu_res,
               trace_ready,
        output rf_we1, rf_waddr1, rf_wdata1, rf_we2, rf_waddr2, rf_wdata2,
               hilo_we, hilo_wdata, debug_wb_pc, debug_wb_rf_wen,
               debug_wb_rf_wnum, debug_wb_rf_wdata, stall_req, commit_cnt
    );
endinterface

// File: rtl/wb_commit_trace.sv
// Dual-issue write-back: drives both regfile ports and HI/LO combinationally,
// and serialises retirements through a small FIFO onto a one-entry-per-cycle
// debug trace port.
module wb_commit_trace #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_trace_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    localparam cnt_t DEPTH_C   = cnt_t'(DEPTH);
    localparam cnt_t STALL_LVL = cnt_t'(DEPTH - 2);

    entry_t           mem [DEPTH];
    ptr_t             wptr;
    ptr_t             rptr;
    cnt_t             count;
    logic             overflow;
    logic [CNT_W-1:0] commit_q;

    logic             mret;
    logic             sret;
    logic             we2;
    logic [31:0]      mdata;
    entry_t           m_entry;
    entry_t           s_entry;
    cnt_t             free_slots;
    cnt_t             n_push;
    logic             push_m;
    logic             push_s;
    logic             pop;

    // Retire qualification; reset masks retirement so nothing commits during it.
    assign mret = ~rst & bus.wb_fire & (bus.W_master_pc != 32'd0) & (bus.W_master_except == 8'd0);
    assign sret = ~rst & bus.wb_fire & (bus.W_slave_pc  != 32'd0) & (bus.W_slave_except  == 8'd0);
    assign mdata = bus.W_master_memtoReg ? bus.W_master_mem_rdata : bus.W_master_alu_res;

    // The slave is younger, so on a same-register write only its value lands.
    assign we2            = sret & bus.W_slave_reg_wen;
    assign bus.rf_we2     = we2;
    assign bus.rf_we1     = mret & bus.W_master_reg_wen
                            & ~(we2 & (bus.W_slave_reg_waddr == bus.W_master_reg_waddr));
    assign bus.rf_waddr1  = bus.W_master_reg_waddr;
    assign bus.rf_wdata1  = mdata;
    assign bus.rf_waddr2  = bus.W_slave_reg_waddr;
    assign bus.rf_wdata2  = bus.W_slave_alu_res;
    assign bus.hilo_we    = mret & bus.W_master_hilowrite;
    assign bus.hilo_wdata = bus.W_master_alu_out64;

    assign m_entry = '{pc: bus.W_master_pc,
                       wen: bus.W_master_reg_wen & (bus.W_master_reg_waddr != 5'd0),
                       wnum: bus.W_master_reg_waddr, wdata: mdata};
    assign s_entry = '{pc: bus.W_slave_pc,
                       wen: bus.W_slave_reg_wen & (bus.W_slave_reg_waddr != 5'd0),
                       wnum: bus.W_slave_reg_waddr, wdata: bus.W_slave_alu_res};

    // Push/pop decisions; pushes beyond the free space are dropped, master first.
    always_comb begin
        free_slots = DEPTH_C - count;
        push_m     = mret & (free_slots != '0);
        push_s     = sret & (free_slots > cnt_t'(push_m));
        n_push     = cnt_t'(push_m) + cnt_t'(push_s);
        pop        = (count != '0) & bus.trace_ready;
    end

    // FIFO storage; contents need no reset because pointers and count gate them.
    always_ff @(posedge clk) begin
        if (push_m) mem[wptr] <= m_entry;
        if (push_s) mem[wptr + ptr_t'(push_m)] <= s_entry;
    end

    // Pointers, occupancy, sticky overflow and the retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            commit_q <= '0;
        end else begin
            wptr     <= wptr + ptr_t'(n_push);
            rptr     <= rptr + ptr_t'(pop);
            count    <= count + n_push - cnt_t'(pop);
            overflow <= overflow | (mret & ~push_m) | (sret & ~push_s);
            commit_q <= commit_q + {{(CNT_W-1){1'b0}}, mret} + {{(CNT_W-1){1'b0}}, sret};
        end
    end

    // Registered trace port: each popped entry is shown for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.debug_wb_pc       <= 32'd0;
            bus.debug_wb_rf_wen   <= 4'h0;
            bus.debug_wb_rf_wnum  <= 5'd0;
            bus.debug_wb_rf_wdata <= 32'd0;
        end else if (pop) begin
            bus.debug_wb_pc       <= mem[rptr].pc;
            bus.debug_wb_rf_wen   <= {4{mem[rptr].wen}};
            bus.debug_wb_rf_wnum  <= mem[rptr].wnum;
            bus.debug_wb_rf_wdata <= mem[rptr].wdata;
        end else begin
            bus.debug_wb_pc       <= 32'd0;
            bus.debug_wb_rf_wen   <= 4'h0;
        end
    end

    // Stall depends only on registered occupancy, never on this cycle's inputs.
    assign bus.stall_req  = count > STALL_LVL;
    assign bus.commit_cnt = commit_q;

    // Upstream must honour stall_req, so a dropped push means a broken pipeline.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow);
endmodule

// File: tb/tb_wb_commit_trace.sv
// Randomised and directed bench for wb_commit_trace against a queue-based
// model of retirement, trace ordering and counters.
module tb_wb_commit_trace;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_commit_trace_if #(.CNT_W(32)) bus();
    wb_commit_trace #(.DEPTH(8), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } tr_t;

    tr_t         q[$];
    tr_t         exp_tr;
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.wb_fire            = 1'b0;
        bus.W_master_reg_wen   = 1'b0;
        bus.W_master_memtoReg  = 1'b0;
        bus.W_master_hilowrite = 1'b0;
        bus.W_master_reg_waddr = 5'd0;
        bus.W_master_except    = 8'd0;
        bus.W_master_pc        = 32'd0;
        bus.W_master_alu_res   = 32'd0;
        bus.W_master_mem_rdata = 32'd0;
        bus.W_master_alu_out64 = 64'd0;
        bus.W_slave_reg_wen    = 1'b0;
        bus.W_slave_reg_waddr  = 5'd0;
        bus.W_slave_except     = 8'd0;
        bus.W_slave_pc         = 32'd0;
        bus.W_slave_alu_res    = 32'd0;
    endtask

    task automatic set_master(input logic [31:0] pc, input logic wen, input logic [4:0] a, input logic [31:0] d);
        bus.wb_fire            = 1'b1;
        bus.W_master_pc        = pc;
        bus.W_master_reg_wen   = wen;
        bus.W_master_reg_waddr = a;
        bus.W_master_alu_res   = d;
        bus.W_master_except    = 8'd0;
    endtask

    task automatic set_slave(input logic [31:0] pc, input logic wen, input logic [4:0] a, input logic [31:0] d);
        bus.wb_fire           = 1'b1;
        bus.W_slave_pc        = pc;
        bus.W_slave_reg_wen   = wen;
        bus.W_slave_reg_waddr = a;
        bus.W_slave_alu_res   = d;
        bus.W_slave_except    = 8'd0;
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step();
        logic        m, s, we1, we2;
        logic [31:0] md;
        tr_t         e;
        if (!rst && q.size() > 6) bus.wb_fire = 1'b0;   // upstream honours stall
        #1;
        m   = !rst && bus.wb_fire && bus.W_master_pc != 0 && bus.W_master_except == 0;
        s   = !rst && bus.wb_fire && bus.W_slave_pc  != 0 && bus.W_slave_except  == 0;
        md  = bus.W_master_memtoReg ? bus.W_master_mem_rdata : bus.W_master_alu_res;
        we2 = s && bus.W_slave_reg_wen;
        we1 = m && bus.W_master_reg_wen && !(we2 && bus.W_slave_reg_waddr == bus.W_master_reg_waddr);

        chk("rf_we1", 64'(bus.rf_we1), 64'(we1));
        chk("rf_we2", 64'(bus.rf_we2), 64'(we2));
        chk("rf_waddr1", 64'(bus.rf_waddr1), 64'(bus.W_master_reg_waddr));
        chk("rf_wdata1", 64'(bus.rf_wdata1), 64'(md));
        chk("rf_wdata2", 64'(bus.rf_wdata2), 64'(bus.W_slave_alu_res));
        chk("hilo_we", 64'(bus.hilo_we), 64'(m && bus.W_master_hilowrite));
        if (bus.hilo_we) chk("hilo_wdata", bus.hilo_wdata, bus.W_master_alu_out64);
        chk("stall_req", 64'(bus.stall_req), 64'(q.size() > 6));
        chk("commit_cnt", 64'(bus.commit_cnt), 64'(exp_cnt));
        chk("trace_pc", 64'(bus.debug_wb_pc), 64'(exp_tr.pc));
        chk("trace_wen", 64'(bus.debug_wb_rf_wen), exp_tr.wen ? 64'hf : 64'h0);
        if (exp_tr.wen) begin
            chk("trace_wnum", 64'(bus.debug_wb_rf_wnum), 64'(exp_tr.wnum));
            chk("trace_wdata", 64'(bus.debug_wb_rf_wdata), 64'(exp_tr.wdata));
        end

        if (rst) begin
            q.delete();
            exp_cnt = 32'd0;
            exp_tr  = '{32'd0, 1'b0, 5'd0, 32'd0};
        end else begin
            if (q.size() != 0 && bus.trace_ready) exp_tr = q.pop_front();
            else begin
                exp_tr.pc  = 32'd0;
                exp_tr.wen = 1'b0;
            end
            if (m) begin
                e = '{bus.W_master_pc, bus.W_master_reg_wen && bus.W_master_reg_waddr != 0,
                      bus.W_master_reg_waddr, md};
                q.push_back(e);
            end
            if (s) begin
                e = '{bus.W_slave_pc, bus.W_slave_reg_wen && bus.W_slave_reg_waddr != 0,
                      bus.W_slave_reg_waddr, bus.W_slave_alu_res};
                q.push_back(e);
            end
            exp_cnt = exp_cnt + 32'(m) + 32'(s);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        set_idle();
        bus.wb_fire            = ($urandom % 4) != 0;
        bus.W_master_pc        = (($urandom % 8) == 0) ? 32'd0 : {$urandom, 2'b00} >> 2 << 2;
        bus.W_slave_pc         = (($urandom % 8) == 0) ? 32'd0 : bus.W_master_pc + 32'd4;
        bus.W_master_except    = (($urandom % 6) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
        bus.W_slave_except     = (($urandom % 6) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
        bus.W_master_reg_wen   = 1'($urandom);
        bus.W_slave_reg_wen    = 1'($urandom);
        bus.W_master_reg_waddr = 5'($urandom);
        bus.W_slave_reg_waddr  = (($urandom % 4) == 0) ? bus.W_master_reg_waddr : 5'($urandom);
        bus.W_master_memtoReg  = 1'($urandom);
        bus.W_master_hilowrite = 1'($urandom);
        bus.W_master_alu_res   = $urandom;
        bus.W_master_mem_rdata = $urandom;
        bus.W_master_alu_out64 = {$urandom, $urandom};
        bus.W_slave_alu_res    = $urandom;
        bus.trace_ready        = ($urandom % 4) != 0;
    endtask

    initial begin
        exp_cnt = 32'd0;
        exp_tr  = '{32'd0, 1'b0, 5'd0, 32'd0};
        rst = 1'b1;
        set_idle();
        bus.trace_ready = 1'b1;
        repeat (2) @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // Dual retire in one cycle, then two trace cycles in program order.
        set_master(32'hbfc00000, 1'b1, 5'd2, 32'h11);
        set_slave (32'hbfc00004, 1'b1, 5'd3, 32'h22);
        step();
        set_idle(); step(); step();

        // Same destination: slave wins the regfile, both still traced.
        set_master(32'hbfc00008, 1'b1, 5'd5, 32'haa);
        set_slave (32'hbfc0000c, 1'b1, 5'd5, 32'hbb);
        step();
        set_idle(); step(); step();

        // Exception and bubble on the master slot.
        set_master(32'hbfc00010, 1'b1, 5'd6, 32'h1);
        bus.W_master_except    = 8'h01;
        bus.W_master_hilowrite = 1'b1;
        step();
        set_idle();
        set_master(32'd0, 1'b1, 5'd6, 32'h2);
        step();
        set_idle(); step();

        // Backpressure: fill until stall, extra groups held, then drain.
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_master(32'h8000_0000 + 32'(i * 8), 1'b1, 5'(i + 1), 32'(i));
            set_slave (32'h8000_0004 + 32'(i * 8), 1'b1, 5'(i + 9), 32'(i + 100));
            step();
        end
        set_idle();
        bus.trace_ready = 1'b1;
        repeat (10) step();

        // Load data and HI/LO write.
        set_master(32'hbfc00100, 1'b1, 5'd7, 32'h1234);
        bus.W_master_memtoReg  = 1'b1;
        bus.W_master_mem_rdata = 32'hdeadbeef;
        bus.W_master_hilowrite = 1'b1;
        bus.W_master_alu_out64 = 64'h0123_4567_89ab_cdef;
        step();
        set_idle(); step(); step();

        // Reset with five entries queued: nothing stale may appear afterwards.
        bus.trace_ready = 1'b0;
        set_master(32'h9000_0000, 1'b1, 5'd1, 32'h1); set_slave(32'h9000_0004, 1'b1, 5'd2, 32'h2); step();
        set_master(32'h9000_0008, 1'b1, 5'd3, 32'h3); set_slave(32'h9000_000c, 1'b1, 5'd4, 32'h4); step();
        set_idle(); set_master(32'h9000_0010, 1'b1, 5'd5, 32'h5); step();
        set_master(32'h9000_0014, 1'b1, 5'd6, 32'h6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_idle();
        bus.trace_ready = 1'b1;
        repeat (6) step();

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst = (($urandom % 300) == 0);
            step();
        end
        rst = 1'b0;
        set_idle();
        bus.trace_ready = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
